imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side companion to the instruction memory. The datapath only ever reads that memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles bytes MSB-first into 32-bit words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the CPU (cpu_hold) until a complete, valid program image has been loaded.

Parameters:
- ADDR_W, 5, instruction-memory address width.
- DEPTH, 32, number of instruction words; maximum legal program length.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  write data.
- cpu_hold  output  1  1 = keep CPU/PC stalled.
- done  output  1  load finished (success or error).
- err  output  1  load failed.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0. Internal word counter, byte index and shift register are all cleared.
- Handshake: a byte is consumed only on a rising edge where in_valid=1 and in_ready=1. in_valid while in_ready=0 is ignored and the byte is not consumed. Gaps of any length between bytes are legal.
- States: IDLE, LEN, DATA, WRITE, DONE, ERR (plus CSUM when the optional feature is compiled in).
- IDLE:
  - in_ready=0.
  - start=1 → LEN; cpu_hold=1, done=0, err=0 from the next cycle.
- LEN:
  - in_ready=1.
  - The first consumed byte is N, the word count.
  - N=0 or N>DEPTH → ERR.
  - Otherwise latch N, clear byte index and word index → DATA.
- DATA:
  - in_ready=1.
  - Each consumed byte is shifted in as word = {word[23:0], byte], so the first byte lands in bits 31:24.
  - The 4th consumed byte → WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_addr=word index, mem_wdata=assembled word.
  - mem_we therefore rises the cycle after the 4th byte handshake.
  - Next: if words written == N → DONE (or CSUM), else word index+1 → DATA.
- DONE:
  - done=1, err=0, cpu_hold=0, in_ready=0.
  - Holds until start or reset.
- ERR:
  - done=1, err=1, cpu_hold=1, in_ready=0.
  - Holds until start or reset.
- start in DONE or ERR → LEN (restart); cpu_hold returns to 1 and done/err clear on the next cycle. start in LEN, DATA, WRITE or CSUM is ignored.
- mem_we=0 in every state except WRITE. mem_addr and mem_wdata hold their last values when mem_we=0.
- No address wrap: N≤DEPTH, so N=32 writes addresses 0..31 and the address never overflows ADDR_W.
- Reset mid-load: return to the reset values on the next edge; no further mem_we. Words already written stay in memory; the loader never clears memory.
- reset and start in the same cycle: reset wins.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter CSUM with in_ready=1 and consume one byte.
  - Compare it with the running XOR of all data bytes (the length byte is excluded); the running XOR is cleared on entry to LEN.
  - Match → DONE. Mismatch → ERR.
- Undefined: the last WRITE goes directly to DONE; err is raised only by an illegal N.

Test Plan:
1. Reset, then 5 cycles with in_valid=1 and no start → in_ready=0, mem_we=0, cpu_hold=1, done=0, err=0 throughout.
2. start, stream 01 DE AD BE EF → single mem_we pulse with mem_addr=0, mem_wdata=32'hDEADBEEF, one cycle after the 4th data byte; then done=1, cpu_hold=0, err=0.
3. start, N=0x20 then 128 bytes with random in_valid gaps (word k = 32'h0000_00kk) → exactly 32 mem_we pulses, addresses 0..31 in order, correct data, no extra writes; then done=1.
4. start, N=0x00 → err=1, done=1, cpu_hold=1, no mem_we. Repeat with N=0x21 → same response. A further start then N=01 and 4 data bytes → successful load.
5. start, N=2, 6 data bytes, reset on the next edge → one write only (addr 0); all outputs at reset values next cycle; no write to addr 1.
6. With IMEM_LOADER_CHECKSUM_EN: N=1, DE AD BE EF, checksum 0x22 → done=1, err=0. Same stream with checksum 0x23 → done=1, err=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader that fills instruction memory and holds the CPU until a full image is in.
// Optional trailing XOR checksum byte is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
`endif

    state_t              state_q, state_d;
    logic [7:0]          n_q, n_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [23:0]         shift_q, shift_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic fire;
    logic last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
`else
    assign in_ready = (state_q == S_LEN) || (state_q == S_DATA);
`endif
    assign fire      = in_valid && in_ready;
    assign last_word = (int'(word_idx_q) + 1) == int'(n_q);

    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = (state_q != S_DONE);
    assign done      = (state_q == S_DONE) || (state_q == S_ERR);
    assign err       = (state_q == S_ERR);

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        shift_d     = shift_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            S_LEN: begin
                if (fire) begin
                    if (in_data == 8'd0 || int'(in_data) > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        n_d        = in_data;
                        byte_idx_d = 2'd0;
                        word_idx_d = '0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    shift_d    = {shift_q[15:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data;
`endif
                    // Capture the word into the output registers so it is stable during WRITE
                    if (byte_idx_q == 2'd3) begin
                        mem_addr_d  = word_idx_q;
                        mem_wdata_d = {shift_q, in_data};
                        state_d     = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    word_idx_d = word_idx_q + ADDR_W'(1);
                    state_d    = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (fire) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= 8'd0;
            byte_idx_q  <= 2'd0;
            word_idx_q  <= '0;
            shift_q     <= 24'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            shift_q     <= shift_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; streams are scored against a stream-level reference model.
module tb_imem_loader;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              reset, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, mem_we, cpu_hold, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]                 stim_q[$];
    logic [ADDR_W+31:0]         log_q[$];
    logic [ADDR_W+31:0]         exp_q[$];
    logic                       exp_err;

    // Observed write log, sampled mid-cycle
    always @(negedge clk) if (mem_we === 1'b1) log_q.push_back({mem_addr, mem_wdata});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        g = $urandom_range(maxgap, 0);
        repeat (g) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; in_ready !== 1'b1; t++) begin
            if (t >= 40) begin
                chk("ready_timeout", 64'd0, 64'd1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        stim_q.push_back(w[31:24]); stim_q.push_back(w[23:16]);
        stim_q.push_back(w[15:8]);  stim_q.push_back(w[7:0]);
    endtask

    // Appends the checksum byte when the feature is built in; bad=1 corrupts it
    task automatic push_csum(input logic bad);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        for (int i = 1; i < stim_q.size(); i++) x ^= stim_q[i];
        stim_q.push_back(bad ? ~x : x);
`else
        if (bad) stim_q.push_back(8'hxx);
`endif
    endtask

    // Reference: what a stream should produce, straight from the load rules
    task automatic ref_model();
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        n = int'(stim_q[0]);
        x = 8'd0;
        if (n == 0 || n > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        exp_err = 1'b0;
        for (int k = 0; k < n; k++) begin
            w = {stim_q[1+4*k], stim_q[2+4*k], stim_q[3+4*k], stim_q[4+4*k]};
            exp_q.push_back({ADDR_W'(k), w});
            x ^= w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_err = (stim_q[1+4*n] != x);
`endif
    endtask

    task automatic run_load(input string tag, input int maxgap);
        int t;
        pulse_start();
        log_q.delete();
        foreach (stim_q[i]) send_byte(stim_q[i], maxgap);
        for (t = 0; t < 10 && done !== 1'b1; t++) @(negedge clk);
        if (t >= 10) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        repeat (2) @(negedge clk);
        ref_model();
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        chk({tag, "_hold"}, 64'(cpu_hold), 64'(exp_err));
        chk({tag, "_nwrites"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            chk({tag, "_write"}, 64'(log_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_hold", 64'(cpu_hold), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b0;

        // 1: bytes offered in IDLE are ignored
        in_valid = 1'b1; in_data = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_state", 64'({in_ready, mem_we, cpu_hold, done, err}), 64'b00100);
        end
        in_valid = 1'b0;

        // 2: single word, write timing
        pulse_start();
        log_q.delete();
        send_byte(8'h01, 0); send_byte(8'hDE, 2); send_byte(8'hAD, 0); send_byte(8'hBE, 1);
        send_byte(8'hEF, 0);
        chk("t2_we", 64'(mem_we), 64'd1);
        chk("t2_addr", 64'(mem_addr), 64'd0);
        chk("t2_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        @(negedge clk);
        chk("t2_we_pulse", 64'(mem_we), 64'd0);
        chk("t2_wdata_hold", 64'(mem_wdata), 64'hDEADBEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h22, 0);
`endif
        chk("t2_fin", 64'({done, cpu_hold, err}), 64'b100);
        chk("t2_nwrites", 64'(log_q.size()), 64'd1);

        // 3: full depth, word k = k, random gaps
        stim_q.delete(); stim_q.push_back(8'h20);
        for (int k = 0; k < 32; k++) push_word(32'(k));
        push_csum(1'b0);
        run_load("t3", 3);

        // 4: illegal lengths, then recovery
        stim_q.delete(); stim_q.push_back(8'h00);
        run_load("t4_n0", 0);
        stim_q.delete(); stim_q.push_back(8'h21);
        run_load("t4_n33", 0);
        stim_q.delete(); stim_q.push_back(8'h01); push_word(32'h1234_5678); push_csum(1'b0);
        run_load("t4_ok", 1);

        // 5: reset mid-load
        pulse_start();
        log_q.delete();
        send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst", 64'({in_ready, mem_we, cpu_hold, done, err}), 64'b00100);
        chk("t5_rst_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_nwrites", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) chk("t5_write0", 64'(log_q[0]), 64'({ADDR_W'(0), 32'hA0A1A2A3}));

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum match / mismatch
        stim_q.delete(); stim_q.push_back(8'h01); push_word(32'hDEADBEEF); stim_q.push_back(8'h22);
        run_load("t6_good", 1);
        stim_q[5] = 8'h23;
        run_load("t6_bad", 1);
`endif

        // randomized loads, including illegal lengths
        for (int r = 0; r < 8; r++) begin
            stim_q.delete();
            if (r == 3) begin
                stim_q.push_back(8'($urandom_range(255, DEPTH + 1)));
            end else begin
                n = $urandom_range(DEPTH, 1);
                stim_q.push_back(8'(n));
                for (int k = 0; k < n; k++) push_word($urandom);
`ifdef IMEM_LOADER_CHECKSUM_EN
                push_csum(r == 5);
`endif
            end
            run_load("rand", 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
